fifo_readout_seq: RTL and testbench
===================================

FIFO_READOUT_SEQ -- requirements
Module: fifo_readout_seq

Interface
REQ-001 Parameter NCH, default 7, number of channel FIFOs read per event.
REQ-002 Parameter DW, default 18, FIFO word width; bits [15:0] are data and bit [DW-1] is the last-word flag.
REQ-003 Parameter TMO, default 255, number of idle READ cycles that triggers a channel timeout.
REQ-004 Port CLKDDU  in  1  sole clock; all logic is on its rising edge.
REQ-005 Port RST  in  1  synchronous, active-high reset.
REQ-006 Port START  in  1  single-cycle event request.
REQ-007 Port DAVMASK  in  NCH  channels holding data for this event.
REQ-008 Port KILL  in  NCH  channels excluded from readout.
REQ-009 Port HALT  in  1  downstream not ready; readout pauses.
REQ-010 Port FFOR_B  in  NCH  active-low, channel FIFO (first-word-fall-through) has a word on DATAIN.
REQ-011 Port DATAIN  in  DW  shared FIFO output bus.
REQ-012 Port RENFIFO_B  out  NCH  active-low read enable, one per channel.
REQ-013 Port OEFIFO_B  out  NCH  active-low output enable, one per channel.
REQ-014 Port DOUT  out  16  output word.
REQ-015 Port DVALID  out  1  DOUT is valid this cycle.
REQ-016 Port BUSY  out  1  event in progress.
REQ-017 Port DONE  out  1  single-cycle end-of-event pulse.
REQ-018 Port TMO_ERR  out  NCH  per-channel timeout flags, held until the next accepted START.

Function
REQ-019 State machine SHALL use the states IDLE, SELECT, ENABLE, READ, GAP, TRAILER and DONE.
REQ-020 In IDLE, START SHALL latch PEND = DAVMASK & ~KILL, clear TMO_ERR and the word count, and go to SELECT; BUSY SHALL be 1 from the next cycle until the DONE state ends, inclusive.
REQ-021 START outside IDLE SHALL be ignored.
REQ-022 SELECT SHALL choose the lowest-index set bit of PEND and go to ENABLE; if PEND==0 it SHALL go to TRAILER.
REQ-023 ENABLE SHALL last one cycle, with OEFIFO_B[ch]=0 and all RENFIFO_B=1.
REQ-024 READ SHALL keep OEFIFO_B[ch]=0 and drive RENFIFO_B[ch] = ~(~FFOR_B[ch] & ~HALT) combinationally; all other channels SHALL stay 1.
REQ-025 A word SHALL be consumed on a cycle where RENFIFO_B[ch]=0.
- Next cycle: DOUT=DATAIN[15:0] and DVALID=1.
- The word count SHALL increment, 12 bits, saturating at 4095.
REQ-026 Consuming a word with DATAIN[DW-1]=1 SHALL clear PEND[ch] and go to GAP.
REQ-027 Timeout counter, ceil(log2(TMO+1)) bits:
- Cleared on entry to READ and on every consumed word.
- Increments on every other READ cycle with HALT=0.
- Frozen while HALT=1.
REQ-028 When the timeout counter reaches TMO, TMO_ERR[ch] SHALL be set, PEND[ch] cleared, and the FSM SHALL go to GAP.
REQ-029 GAP SHALL last one cycle with all OEFIFO_B=1 (bus turnaround), then go to SELECT.
REQ-030 TRAILER SHALL last one cycle; in the following cycle DOUT={4'hE, count[11:0]} and DVALID=1.
REQ-031 In the DONE state, DONE SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-032 At most one OEFIFO_B bit SHALL be low at any time, and never in IDLE, SELECT, GAP, TRAILER or DONE.
REQ-033 DVALID SHALL be 0 on every cycle not covered by REQ-025 or REQ-030.
REQ-034 A last-word consume and a timeout in the same cycle SHALL be treated as a normal last-word consume; TMO_ERR is not set.
REQ-035 A channel with PEND set but FFOR_B permanently high SHALL time out after exactly TMO non-HALT READ cycles.

Reset
REQ-036 RST=1 at any edge, including mid-event, SHALL force IDLE and clear PEND and both counters.
REQ-037 Reset output values: RENFIFO_B and OEFIFO_B all ones, DOUT=0, DVALID=0, BUSY=0, DONE=0, TMO_ERR=0.
REQ-038 START sampled together with RST SHALL be ignored.

Verification
REQ-039 Basic readout: NCH=7, DAVMASK=7'b0100001, ch0 holds 2 words, ch5 holds 3 words (last flag on each final word), START pulse -> 5 data words in order ch0 then ch5, one GAP between channels, trailer DOUT=16'hE005, one DONE pulse.
REQ-040 Kill and empty event: DAVMASK=7'h01, KILL=7'h01 -> no OEFIFO_B low, trailer DOUT=16'hE000, DONE pulse 3 cycles after START.
REQ-041 Timeout: TMO=8, DAVMASK=7'h04, FFOR_B[2] held high -> TMO_ERR=7'h04 after 8 READ cycles, trailer DOUT=16'hE000.
REQ-042 Backpressure: HALT=1 for 20 cycles mid-channel on the REQ-041 setup -> RENFIFO_B stays all ones, no timeout, word sequence unchanged.
REQ-043 Reset in READ: RST asserted during READ -> next cycle all outputs at reset values; a following START runs a complete event.

Source files
------------

// File: rtl/fifo_readout_seq.sv
// Event readout sequencer: drains NCH first-word-fall-through channel FIFOs
// over a shared bus, lowest channel first, then emits a word-count trailer.
// Ports: CLKDDU/RST clock and sync reset; START/DAVMASK/KILL event request;
//   HALT downstream backpressure; FFOR_B/DATAIN FIFO side;
//   RENFIFO_B/OEFIFO_B FIFO strobes; DOUT/DVALID output words;
//   BUSY/DONE event status; TMO_ERR per-channel timeout flags.
module fifo_readout_seq #(
  parameter int NCH = 7,
  parameter int DW  = 18,
  parameter int TMO = 255
) (
  input  logic           CLKDDU,
  input  logic           RST,
  input  logic           START,
  input  logic [NCH-1:0] DAVMASK,
  input  logic [NCH-1:0] KILL,
  input  logic           HALT,
  input  logic [NCH-1:0] FFOR_B,
  input  logic [DW-1:0]  DATAIN,
  output logic [NCH-1:0] RENFIFO_B,
  output logic [NCH-1:0] OEFIFO_B,
  output logic [15:0]    DOUT,
  output logic           DVALID,
  output logic           BUSY,
  output logic           DONE,
  output logic [NCH-1:0] TMO_ERR
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ENABLE,
    ST_READ,
    ST_GAP,
    ST_TRAILER,
    ST_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [TW-1:0]  tcnt_inc;
  logic [11:0]    wcnt_q, wcnt_d;
  logic [NCH-1:0] tmo_err_q, tmo_err_d;
  logic [NCH-1:0] oe_q, oe_d;
  logic [15:0]    dout_q, dout_d;
  logic           dvalid_q, dvalid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           consume;
  logic [NCH-1:0] ren_b;

  if (DW > 17) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^DATAIN[DW-2:16];
  end

  // Read strobe is combinational so a word is taken the same cycle
  // the FIFO shows it and downstream is ready.
  assign consume = (state_q == ST_READ) & ~FFOR_B[ch_q] & ~HALT;

  always_comb begin
    ren_b = '1;
    if (consume) ren_b[ch_q] = 1'b0;
  end

  assign tcnt_inc = tcnt_q + TW'(1);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ch_d      = ch_q;
    tcnt_d    = tcnt_q;
    wcnt_d    = wcnt_q;
    tmo_err_d = tmo_err_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          pend_d    = DAVMASK & ~KILL;
          tmo_err_d = '0;
          wcnt_d    = '0;
          state_d   = ST_SELECT;
        end
      end
      ST_SELECT: begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (pend_q[i]) ch_d = CW'(i);
        end
        state_d = (|pend_q) ? ST_ENABLE : ST_TRAILER;
      end
      ST_ENABLE: begin
        tcnt_d  = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (consume) begin
          dout_d   = DATAIN[15:0];
          dvalid_d = 1'b1;
          tcnt_d   = '0;
          if (wcnt_q != 12'hFFF) wcnt_d = wcnt_q + 12'd1;
          if (DATAIN[DW-1]) begin
            pend_d[ch_q] = 1'b0;
            state_d      = ST_GAP;
          end
        end else if (!HALT) begin
          // Idle READ cycle: the TMO-th one abandons the channel.
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TW'(TMO)) begin
            tmo_err_d[ch_q] = 1'b1;
            pend_d[ch_q]    = 1'b0;
            state_d         = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_SELECT;
      end
      ST_TRAILER: begin
        dout_d   = {4'hE, wcnt_q};
        dvalid_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output enable tracks the next state so it is a clean flop output.
    oe_d = '1;
    if (state_d == ST_ENABLE || state_d == ST_READ) oe_d[ch_d] = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLKDDU) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      ch_q      <= '0;
      tcnt_q    <= '0;
      wcnt_q    <= '0;
      tmo_err_q <= '0;
      oe_q      <= '1;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ch_q      <= ch_d;
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      tmo_err_q <= tmo_err_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign RENFIFO_B = ren_b;
  assign OEFIFO_B  = oe_q;
  assign DOUT      = dout_q;
  assign DVALID    = dvalid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign TMO_ERR   = tmo_err_q;

endmodule

// File: tb/tb_fifo_readout_seq.sv
// Bench for fifo_readout_seq: FIFO model, expected-word scoreboard,
// directed events for readout, kill, timeout, backpressure and reset.
module tb_fifo_readout_seq;
  localparam int NCH = 7;
  localparam int DW  = 18;
  localparam int TMO = 8;

  logic           CLKDDU = 1'b0;
  logic           RST;
  logic           START;
  logic [NCH-1:0] DAVMASK;
  logic [NCH-1:0] KILL;
  logic           HALT;
  logic [NCH-1:0] FFOR_B = '1;
  logic [DW-1:0]  DATAIN = '0;
  logic [NCH-1:0] RENFIFO_B;
  logic [NCH-1:0] OEFIFO_B;
  logic [15:0]    DOUT;
  logic           DVALID;
  logic           BUSY;
  logic           DONE;
  logic [NCH-1:0] TMO_ERR;

  int compared = 0;
  int mismatched = 0;
  int oe_low_cycles = 0;
  int done_cnt = 0;
  bit oe_seen = 0;

  logic [15:0]    exp_q[$];
  logic [DW-1:0]  fq[NCH][$];
  logic [NCH-1:0] hold_high = '0;
  logic [NCH-1:0] ren_snap;

  fifo_readout_seq #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
    .CLKDDU(CLKDDU), .RST(RST), .START(START),
    .DAVMASK(DAVMASK), .KILL(KILL), .HALT(HALT),
    .FFOR_B(FFOR_B), .DATAIN(DATAIN),
    .RENFIFO_B(RENFIFO_B), .OEFIFO_B(OEFIFO_B),
    .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY),
    .DONE(DONE), .TMO_ERR(TMO_ERR)
  );

  always #5 CLKDDU = ~CLKDDU;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLKDDU) begin
    if (DVALID) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL dout_extra: got %0h expected none", DOUT);
      end else begin
        check("dout", 32'(DOUT), 32'(exp_q.pop_front()));
      end
    end
    check("oe_onehot", 32'($countones(~OEFIFO_B) <= 1), 32'd1);
    if (OEFIFO_B != '1) begin
      oe_seen = 1;
      oe_low_cycles++;
    end
    if (DONE) done_cnt++;
  end

  // Channel FIFO model
  always begin
    @(negedge CLKDDU);
    ren_snap = RENFIFO_B;
    @(posedge CLKDDU);
    for (int i = 0; i < NCH; i++) begin
      if (!ren_snap[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    end
    #2;
    for (int i = 0; i < NCH; i++) begin
      FFOR_B[i] = (fq[i].size() == 0) || hold_high[i];
    end
    DATAIN = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!OEFIFO_B[i] && fq[i].size() > 0) DATAIN = fq[i][0];
    end
  end

  function automatic logic [DW-1:0] wd(input bit last,
                                       input logic [15:0] d);
    return {last, 1'b0, d};
  endfunction

  task automatic put(input int ch, input bit last,
                     input logic [15:0] d);
    fq[ch].push_back(wd(last, d));
    exp_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge CLKDDU);
    #1;
  endtask

  task automatic start_ev();
    oe_low_cycles = 0;
    oe_seen = 0;
    START = 1'b1;
    @(negedge CLKDDU);
    @(posedge CLKDDU);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc,
                           input int max);
    int c;
    bit got;
    got = 0;
    for (c = 1; c <= max; c++) begin
      @(negedge CLKDDU);
      if (DONE) begin
        got = 1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (exp_cyc > 0) check({name, "_done_cycle"}, 32'(c), 32'(exp_cyc));
      check({name, "_busy_in_done"}, 32'(BUSY), 32'd1);
      @(negedge CLKDDU);
      check({name, "_busy_after"}, 32'(BUSY), 32'd0);
      check({name, "_done_width"}, 32'(DONE), 32'd0);
    end
    @(posedge CLKDDU);
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ren"}, 32'(RENFIFO_B), 32'h7F);
    check({name, "_oe"}, 32'(OEFIFO_B), 32'h7F);
    check({name, "_dout"}, 32'(DOUT), 32'h0);
    check({name, "_dvalid"}, 32'(DVALID), 32'h0);
    check({name, "_busy"}, 32'(BUSY), 32'h0);
    check({name, "_done"}, 32'(DONE), 32'h0);
    check({name, "_tmo_err"}, 32'(TMO_ERR), 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    HALT = 1'b0;
    DAVMASK = '0;
    KILL = '0;
    repeat (3) tick();
    @(negedge CLKDDU);
    check_reset_vals("reset");

    // START together with RST is ignored
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    tick();
    @(negedge CLKDDU);
    check("start_in_reset_busy", 32'(BUSY), 32'd0);
    tick();

    // Basic readout: ch0 two words, ch5 three words
    put(0, 0, 16'h1234);
    put(0, 1, 16'h5678);
    put(5, 0, 16'hA001);
    put(5, 0, 16'hA002);
    put(5, 1, 16'hA003);
    exp_q.push_back(16'hE005);
    DAVMASK = 7'b0100001;
    tick();
    start_ev();
    wait_done("basic", 14, 60);
    check("basic_oe_cycles", 32'(oe_low_cycles), 32'd7);
    check("basic_tmo_err", 32'(TMO_ERR), 32'h0);
    check("basic_drained", 32'(exp_q.size()), 32'd0);

    // Killed channel, empty event
    fq[0].push_back(wd(1, 16'hDEAD));
    exp_q.push_back(16'hE000);
    DAVMASK = 7'h01;
    KILL = 7'h01;
    tick();
    start_ev();
    wait_done("kill", 3, 20);
    check("kill_no_oe", 32'(oe_seen), 32'd0);
    check("kill_not_read", 32'(fq[0].size()), 32'd1);
    fq[0].delete();
    KILL = '0;
    tick();

    // Timeout on a channel that never presents data
    hold_high = 7'h04;
    exp_q.push_back(16'hE000);
    DAVMASK = 7'h04;
    tick();
    start_ev();
    wait_done("tmo", 14, 40);
    check("tmo_err", 32'(TMO_ERR), 32'h04);
    check("tmo_oe_cycles", 32'(oe_low_cycles), 32'(TMO + 1));
    hold_high = '0;
    tick();

    // Backpressure mid-channel, FIFO also looks empty meanwhile
    put(2, 0, 16'h0B01);
    put(2, 0, 16'h0B02);
    put(2, 1, 16'h0B03);
    exp_q.push_back(16'hE003);
    tick();
    start_ev();
    @(negedge CLKDDU);
    check("halt_tmo_cleared", 32'(TMO_ERR), 32'h0);
    tick();
    tick();
    tick();
    HALT = 1'b1;
    hold_high = 7'h04;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLKDDU);
      check("halt_ren", 32'(RENFIFO_B), 32'h7F);
      tick();
    end
    @(negedge CLKDDU);
    check("halt_still_reading", 32'(OEFIFO_B), 32'h7B);
    check("halt_no_tmo", 32'(TMO_ERR), 32'h0);
    tick();
    HALT = 1'b0;
    hold_high = '0;
    wait_done("halt", 0, 40);
    check("halt_tmo_final", 32'(TMO_ERR), 32'h0);
    check("halt_drained", 32'(exp_q.size()), 32'd0);

    // Reset while in READ, then a full event
    fq[1].push_back(wd(0, 16'hC001));
    fq[1].push_back(wd(1, 16'hC002));
    hold_high = 7'h02;
    DAVMASK = 7'h02;
    tick();
    start_ev();
    tick();
    tick();
    @(negedge CLKDDU);
    check("rst_in_read_oe", 32'(OEFIFO_B), 32'h7D);
    RST = 1'b1;
    tick();
    @(negedge CLKDDU);
    check_reset_vals("rst_mid");
    RST = 1'b0;
    hold_high = '0;
    exp_q.push_back(16'hC001);
    exp_q.push_back(16'hC002);
    exp_q.push_back(16'hE002);
    tick();
    tick();
    start_ev();
    wait_done("post_rst", 8, 30);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
